// File: rtl/sm_sub_pkg.sv
// rtl/sm_sub_pkg.sv - shared types for the two-requester sign-magnitude subtract arbiter
package sm_sub_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/subtract.sv
// rtl/subtract.sv - combinational sign-magnitude subtractor a - b, N bits including sign
module subtract #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] out,
    output logic         carry
);

    logic         sign_a;
    logic         sign_b;
    logic         sign_r;
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic [N-2:0] mag_r;
    logic [N-1:0] mag_sum;

    always_comb begin
        sign_a  = a[N-1];
        sign_b  = b[N-1];
        mag_a   = a[N-2:0];
        mag_b   = b[N-2:0];
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        sign_r  = sign_a;
        carry   = 1'b0;
        mag_r   = mag_sum[N-2:0];
        // Equal signs reduce to a magnitude difference; zero keeps sign_a (no normalisation).
        if (sign_a == sign_b) begin
            if (mag_a >= mag_b) begin
                mag_r = mag_a - mag_b;
            end else begin
                mag_r  = mag_b - mag_a;
                sign_r = ~sign_a;
            end
        end else begin
            carry = mag_sum[N-1];
        end
        out = {sign_r, mag_r};
    end

endmodule

// File: rtl/sm_sub_arbiter.sv
// rtl/sm_sub_arbiter.sv - round-robin sharing of one subtract instance between two requesters
module sm_sub_arbiter
    import sm_sub_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_req_ready,
    input  logic [N-1:0]       i_a0,
    input  logic [N-1:0]       i_b0,
    input  logic [N-1:0]       i_a1,
    input  logic [N-1:0]       i_b1,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic               o_rsp_id,
    output logic [N-1:0]       o_rsp_out,
    output logic               o_rsp_carry,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_count
);

    state_t         state_q;
    state_t         state_d;
    req_id_t        prio_q;
    req_id_t        winner;
    logic           any_valid;
    logic           accept;
    logic           rsp_fire;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    req_id_t        op_id_q;
    logic [N-1:0]   sub_out;
    logic           sub_carry;
    logic [N-1:0]   rsp_out_q;
    logic           rsp_carry_q;
    req_id_t        rsp_id_q;
    logic [CNT_W-1:0] count_q;

    // With both requesters valid the pointer decides; it always names the one not last served.
    always_comb begin
        any_valid = |i_req_valid;
        if (i_req_valid == 2'b11) begin
            winner = prio_q;
        end else begin
            winner = i_req_valid[1];
        end
    end

    assign accept   = (state_q == ST_IDLE) && any_valid;
    assign rsp_fire = (state_q == ST_RESP) && i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (accept && !i_rst) begin
            o_req_ready[winner] = 1'b1;
        end
        o_rsp_valid = (state_q == ST_RESP);
        o_busy      = (state_q != ST_IDLE);
    end

    subtract #(.N(N)) u_subtract (
        .a     (a_q),
        .b     (b_q),
        .out   (sub_out),
        .carry (sub_carry)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_id_q     <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                op_id_q <= winner;
                a_q     <= winner ? i_a1 : i_a0;
                b_q     <= winner ? i_b1 : i_b0;
            end
            if (state_q == ST_EXEC) begin
                rsp_out_q   <= sub_out;
                rsp_carry_q <= sub_carry;
                rsp_id_q    <= op_id_q;
            end
            if (rsp_fire) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                prio_q  <= ~rsp_id_q;
            end
        end
    end

    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_out   = rsp_out_q;
    assign o_rsp_carry = rsp_carry_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_sm_sub_arbiter.sv
// tb/tb_sm_sub_arbiter.sv - directed scoreboard bench for sm_sub_arbiter
module tb_sm_sub_arbiter;

    typedef struct {
        logic       id;
        logic [7:0] out;
        logic       carry;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  a0, b0, a1, b1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [7:0]  rsp_out;
    logic [15:0] count;

    logic [1:0]  w_req_valid;
    logic [1:0]  w_req_ready;
    logic [7:0]  w_a0, w_b0, w_a1, w_b1;
    logic        w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_carry, w_busy;
    logic [7:0]  w_rsp_out;
    logic [2:0]  w_count;

    exp_t        sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          exp_count = 0;

    sm_sub_arbiter #(.N(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_out(rsp_out), .o_rsp_carry(rsp_carry), .o_busy(busy), .o_count(count)
    );

    sm_sub_arbiter #(.N(8), .CNT_W(3)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_req_valid(w_req_valid), .o_req_ready(w_req_ready),
        .i_a0(w_a0), .i_b0(w_b0), .i_a1(w_a1), .i_b1(w_b1),
        .o_rsp_valid(w_rsp_valid), .i_rsp_ready(w_rsp_ready), .o_rsp_id(w_rsp_id),
        .o_rsp_out(w_rsp_out), .o_rsp_carry(w_rsp_carry), .o_busy(w_busy), .o_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Handles the response side: pop the scoreboard, optionally stall, then handshake.
    task automatic respond(input int bp);
        exp_t e;
        int   k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_valid_timeout", rsp_valid, 1);
        e = sb_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_out", rsp_out, e.out);
        chk("rsp_carry", rsp_carry, e.carry);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_out", rsp_out, e.out);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_count", count, exp_count);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count++;
        chk("count", count, exp_count);
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    // Caller sets operands and valids; this checks the grant, latency and the response.
    task automatic run_op(input logic id, input bit hold, input logic [7:0] e_out,
                          input logic e_carry, input int bp);
        exp_t e;
        int   k = 0;
        #1;
        while (req_ready == 2'b00 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("grant", req_ready, id ? 2'b10 : 2'b01);
        e.id = id;
        e.out = e_out;
        e.carry = e_carry;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) req_valid[id] = 1'b0;
        chk("exec_busy", busy, 1);
        chk("exec_ready", req_ready, 2'b00);
        chk("exec_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("latency_t2", rsp_valid, 1);
        respond(bp);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        a0 = 8'h05; b0 = 8'h03; a1 = 8'h03; b1 = 8'h05;
        w_req_valid = 2'b00; w_rsp_ready = 1'b0;
        w_a0 = 8'h05; w_b0 = 8'h03; w_a1 = 8'h00; w_b1 = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);

        // Both requesters valid from reset: grants alternate starting at 0.
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 1'b1, 8'h02, 1'b0, 0);
        run_op(1'b1, 1'b1, 8'h82, 1'b0, 0);
        run_op(1'b0, 1'b1, 8'h02, 1'b0, 0);
        run_op(1'b1, 1'b1, 8'h82, 1'b0, 0);
        chk("count_after_4", count, 4);
        req_valid = 2'b00;

        req_valid = 2'b01; a0 = 8'h05; b0 = 8'h03;
        run_op(1'b0, 1'b0, 8'h02, 1'b0, 0);
        req_valid = 2'b10; a1 = 8'h03; b1 = 8'h05;
        run_op(1'b1, 1'b0, 8'h82, 1'b0, 0);
        req_valid = 2'b10; a1 = 8'h05; b1 = 8'h83;
        run_op(1'b1, 1'b0, 8'h08, 1'b0, 0);
        req_valid = 2'b10; a1 = 8'h7F; b1 = 8'hFF;
        run_op(1'b1, 1'b0, 8'h7E, 1'b1, 0);
        req_valid = 2'b10; a1 = 8'h85; b1 = 8'h85;
        run_op(1'b1, 1'b0, 8'h80, 1'b0, 0);
        req_valid = 2'b01; a0 = 8'h83; b0 = 8'h05;
        run_op(1'b0, 1'b0, 8'h88, 1'b0, 0);
        req_valid = 2'b01; a0 = 8'h02; b0 = 8'h07;
        run_op(1'b0, 1'b0, 8'h85, 1'b0, 0);

        // Backpressure with the other requester waiting: nothing may be granted meanwhile.
        req_valid = 2'b01; a0 = 8'h10; b0 = 8'h01; a1 = 8'h01; b1 = 8'h01;
        run_op(1'b0, 1'b0, 8'h0F, 1'b0, 0);
        req_valid = 2'b11;
        run_op(1'b1, 1'b1, 8'h00, 1'b0, 5);
        req_valid = 2'b00;

        // Reset while the operation sits in EXEC: discarded, counter cleared.
        req_valid = 2'b01; a0 = 8'h05; b0 = 8'h03;
        #1;
        chk("pre_rst_grant", req_ready, 2'b01);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_count", count, exp_count);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        chk("midrst_count_hold", count, exp_count);

        // Narrow-counter instance wraps after 2^3 responses.
        w_req_valid = 2'b01;
        w_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int k = 0;
            while (!w_rsp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("w_rsp_valid_timeout", w_rsp_valid, 1);
            chk("w_rsp_out", w_rsp_out, 8'h02);
            @(negedge clk);
            if (i == 6) chk("w_count_max", w_count, 3'd7);
            if (i == 7) chk("w_count_wrap", w_count, 3'd0);
        end
        w_req_valid = 2'b00;
        w_rsp_ready = 1'b0;

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
